// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage behind the VGA timing generator. Prefetches 16-bit
// framebuffer words over a single-outstanding req/ack port into a small
// FIFO and emits one RGB332 pixel per visible clock (high byte first).
module vga_pixel_fetch #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 20
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_visible,
    input  logic              i_hSync,
    input  logic              i_vSync,
    input  logic              i_inth,
    input  logic              i_intv,
    input  logic [ADDR_W-1:0] i_fbBase,
    output logic              o_memReq,
    output logic [ADDR_W-1:0] o_memAddr,
    input  logic              i_memAck,
    input  logic [15:0]       i_memData,
    output logic [7:0]        o_pixel,
    output logic              o_de,
    output logic              o_hSync,
    output logic              o_vSync,
    output logic              o_underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [PTR_W:0]    CNT_FULL = FIFO_DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]    CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [15:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              phase_q, phase_d;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [7:0]        pixel_q, pixel_d;
    logic              de_q, hsync_q, vsync_q;
    logic              underrun_q, underrun_d;

    logic              fifo_empty;
    logic              fifo_wr;
    logic              fifo_pop;
    logic [15:0]       head_word;

    assign fifo_empty = (count_q == '0);
    assign head_word  = fifo_mem_q[rd_ptr_q];

    // Pixel selection from the head word; a word is popped after its low byte.
    always_comb begin
        pixel_d    = 8'h00;
        fifo_pop   = 1'b0;
        phase_d    = phase_q;
        underrun_d = underrun_q;
        if (i_visible) begin
            if (fifo_empty) begin
                underrun_d = 1'b1;
            end else begin
                pixel_d  = phase_q ? head_word[7:0] : head_word[15:8];
                fifo_pop = phase_q;
            end
            phase_d = ~phase_q;
        end
        // Every line starts on a high byte, whatever the previous line did.
        if (i_inth || i_intv) begin
            phase_d = 1'b0;
        end
    end

    // Fetch FSM: one request at a time; a restart mid-request drains the ack.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        addr_cnt_d = addr_cnt_q;
        fifo_wr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != CNT_FULL && !i_intv) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_cnt_q;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_memAck) begin
                    // An ack coinciding with a restart is simply dropped.
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                    if (!i_intv) begin
                        fifo_wr    = 1'b1;
                        addr_cnt_d = addr_cnt_q + ADDR_ONE;
                    end
                end else if (i_intv) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (i_memAck) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        if (i_intv) begin
            addr_cnt_d = i_fbBase;
        end
    end

    // FIFO pointer and occupancy bookkeeping; a restart flushes everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_intv) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (fifo_wr && !fifo_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!fifo_wr && fifo_pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // FIFO storage, no reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (fifo_wr) begin
            fifo_mem_q[wr_ptr_q] <= i_memData;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            phase_q    <= 1'b0;
            state_q    <= ST_IDLE;
            addr_cnt_q <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            pixel_q    <= 8'h00;
            de_q       <= 1'b0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            phase_q    <= phase_d;
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            pixel_q    <= pixel_d;
            de_q       <= i_visible;
            hsync_q    <= i_hSync;
            vsync_q    <= i_vSync;
            underrun_q <= underrun_d;
        end
    end

    assign o_memReq   = mem_req_q;
    assign o_memAddr  = mem_addr_q;
    assign o_pixel    = pixel_q;
    assign o_de       = de_q;
    assign o_hSync    = hsync_q;
    assign o_vSync    = vsync_q;
    assign o_underrun = underrun_q;

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Downstream stage of the VGA timing generator. Consumes its visible, sync and end-of-line/end-of-frame strobes.
- Fetches 16-bit framebuffer words from memory over a single-outstanding req/ack port into a small prefetch FIFO.
- Emits one 8-bit RGB332 pixel per clock during visible time, with syncs and data-enable delayed to stay aligned.
- Each word holds two pixels: high byte first, then low byte.

Parameters:
- FIFO_DEPTH, 8, prefetch FIFO depth in 16-bit words. Power of two, 4..64.
- ADDR_W, 20, memory word-address width.

Ports:
- i_clk  in  1  pixel clock
- i_reset  in  1  synchronous, active-high reset
- i_visible  in  1  visible-area flag from timing generator
- i_hSync  in  1  horizontal sync from timing generator
- i_vSync  in  1  vertical sync from timing generator
- i_inth  in  1  end-of-line strobe, 1 cycle
- i_intv  in  1  end-of-frame strobe, 1 cycle; coincides with i_inth
- i_fbBase  in  ADDR_W  framebuffer base word address, sampled at frame restart
- o_memReq  out  1  read request, held until acknowledged
- o_memAddr  out  ADDR_W  word address, stable while o_memReq=1
- i_memAck  in  1  1-cycle acknowledge; i_memData valid in the same cycle
- i_memData  in  16  read data
- o_pixel  out  8  RGB332 pixel, 0 when not visible
- o_de  out  1  data enable (i_visible delayed 1 cycle)
- o_hSync  out  1  i_hSync delayed 1 cycle
- o_vSync  out  1  i_vSync delayed 1 cycle
- o_underrun  out  1  sticky: a pixel was needed while the FIFO was empty

Behaviour:
- Reset values:
  - o_memReq=0, o_memAddr=0, o_pixel=0, o_de=0, o_hSync=0, o_vSync=0, o_underrun=0.
  - FIFO empty, phase=0, fetch FSM in IDLE, address counter=0.
  - First fetch after reset starts from 0. i_fbBase is loaded only at frame restart.
- Output pipeline:
  - o_de, o_hSync and o_vSync are registered copies of their inputs: exactly 1 cycle latency.
  - o_pixel is registered with the same 1-cycle latency.
- Pixel path, evaluated each cycle with i_visible=1:
  - phase=0: pixel = head word [15:8], phase becomes 1.
  - phase=1: pixel = head word [7:0], head word is popped, phase becomes 0.
  - FIFO empty on either phase: pixel=0, no pop, o_underrun set to 1. Phase still toggles.
  - i_visible=0: pixel=0, no pop, phase unchanged.
  - i_inth forces phase=0. Visible width must be even; an odd width is unsupported.
- Fetch FSM, 3 states:
  - IDLE: if FIFO count < FIFO_DEPTH and no restart this cycle, then o_memReq<=1 with o_memAddr=address counter; go to REQ.
  - REQ: hold o_memReq and o_memAddr. On i_memAck, write i_memData to the FIFO, increment the address counter (wraps modulo 2^ADDR_W), o_memReq<=0, go to IDLE. A new request is issued no earlier than the cycle after the ack.
  - DRAIN: entered on restart while in REQ. Keep o_memReq=1 until i_memAck, then discard i_memData, o_memReq<=0, go to IDLE.
  - At most one request is outstanding, so an ack never finds the FIFO full.
- Frame restart (i_intv=1):
  - Flush the FIFO (count=0), load the address counter from i_fbBase, phase=0.
  - A write or pop in the same cycle is overridden by the flush.
  - If in REQ, go to DRAIN: the in-flight word is dropped and the address counter is not incremented for it.
- Simultaneous FIFO write and pop: count unchanged, data order preserved.
- o_underrun clears only on i_reset.
- i_reset mid-transaction: o_memReq drops on the next edge. Any later ack is ignored while in IDLE.

Test Plan:
1. Reset, then i_intv pulse with i_fbBase=0x01000, memory acks 1 cycle after each req -> requests at addresses 0x01000..0x01007 issued; FIFO full (8 words); o_memReq stays 0 afterwards.
2. FIFO prefilled with words 0xA1B2, 0xC3D4; i_visible high 4 cycles -> o_pixel = A1, B2, C3, D4 on the cycles 1 after each visible cycle; o_de high for the same 4 cycles.
3. Hold i_memAck low for 20 cycles with FIFO prefilled with 2 words, 8 visible cycles -> pixels A1, B2, C3, D4, then 00, 00, 00, 00; o_underrun=1 and stays 1 after the next i_intv.
4. i_intv while in REQ at address 0x01005, ack 3 cycles later with data 0xFFFF -> 0xFFFF not written; FIFO empty after the ack; next request is to i_fbBase.
5. i_hSync/i_vSync toggle patterns -> o_hSync/o_vSync match inputs shifted exactly 1 cycle.
6. i_reset asserted while o_memReq=1 -> all outputs 0 on the next edge; a late ack does not change the FIFO count.
